// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: Diff = A + ~B + 1, one SLICE-bit chunk per clock with a registered carry.
// Diff and the flags are registered and hold until the next operation completes.
module serial_subtractor #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow,
   output logic             Overflow,
   output logic             Zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [SLICE-1:0] aSlice;
   logic [SLICE-1:0] bSlice;
   logic [SLICE:0]   sliceSum;
   logic [WIDTH-1:0] partNext;
   logic             accept;

   // Only slice k of each operand feeds the SLICE-wide adder; the sum drops into the cleared partial register.
   always_comb begin
      aSlice   = SLICE'(opA_q >> (int'(k_q) * SLICE));
      bSlice   = SLICE'(opB_q >> (int'(k_q) * SLICE));
      sliceSum = {1'b0, aSlice} + {1'b0, bSlice} + {{SLICE{1'b0}}, c_q};
      partNext = part_q | (WIDTH'(sliceSum[SLICE-1:0]) << (int'(k_q) * SLICE));
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      c_d      = c_q;
      opA_d    = opA_q;
      opB_d    = opB_q;
      part_d   = part_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      accept   = 1'b0;
      case (state_q)
         IDLE: accept = start;
         DONE: begin
            accept = start;
            if (!start) state_d = IDLE;
         end
         RUN: begin
            part_d = partNext;
            c_d    = sliceSum[SLICE];
            k_d    = k_q + 1'b1;
            if (k_q == K_LAST) begin
               state_d  = DONE;
               k_d      = '0;
               diff_d   = partNext;
               borrow_d = ~sliceSum[SLICE];
               ovf_d    = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) && (partNext[WIDTH-1] != opA_q[WIDTH-1]);
               zero_d   = (partNext == '0);
            end
         end
         default: state_d = IDLE;
      endcase
      // opB holds ~B, so the +1 of two's complement enters as the initial carry.
      if (accept) begin
         state_d = RUN;
         opA_d   = A;
         opB_d   = ~B;
         c_d     = 1'b1;
         k_d     = '0;
         part_d  = '0;
      end
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         k_q      <= '0;
         c_q      <= 1'b0;
         opA_q    <= '0;
         opB_q    <= '0;
         part_q   <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         c_q      <= c_d;
         opA_q    <= opA_d;
         opB_q    <= opB_d;
         part_q   <= part_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign Diff     = diff_q;
   assign Borrow   = borrow_q;
   assign Overflow = ovf_q;
   assign Zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit-slice and a single-slice instance checked against A-B.
`timescale 1ns/1ps
module tb_serial_subtractor;

   typedef struct {
      logic [31:0] diff;
      logic        borrow;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, start32;
   logic [31:0] A, B;
   logic        busy8, done8, borrow8, ovf8, zero8;
   logic        busy32, done32, borrow32, ovf32, zero32;
   logic [31:0] diff8, diff32;

   exp_t q8[$];
   exp_t q32[$];
   int   checks = 0;
   int   errors = 0;

   serial_subtractor #(.WIDTH(32), .SLICE(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .A(A), .B(B),
      .busy(busy8), .done(done8), .Diff(diff8),
      .Borrow(borrow8), .Overflow(ovf8), .Zero(zero8)
   );

   serial_subtractor #(.WIDTH(32), .SLICE(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .A(A), .B(B),
      .busy(busy32), .done(done32), .Diff(diff32),
      .Borrow(borrow32), .Overflow(ovf32), .Zero(zero32)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [31:0] d, input logic br, input logic ov, input logic z);
      exp_t e;
      e.diff   = d;
      e.borrow = br;
      e.ovf    = ov;
      e.zero   = z;
      return e;
   endfunction

   // Reference: plain 32-bit difference, unsigned compare, and a wide signed difference for overflow.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sd;
      sd       = longint'($signed(a)) - longint'($signed(b));
      e.diff   = a - b;
      e.borrow = (a < b);
      e.ovf    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      e.zero   = (e.diff == 32'd0);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (done8 === 1'b1) begin
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut8 unexpected done: got done=1, expected no pending result");
         end else begin
            e = q8.pop_front();
            checkOutput("dut8 Diff", diff8, e.diff);
            checkOutput("dut8 Borrow", 32'(borrow8), 32'(e.borrow));
            checkOutput("dut8 Overflow", 32'(ovf8), 32'(e.ovf));
            checkOutput("dut8 Zero", 32'(zero8), 32'(e.zero));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (done32 === 1'b1) begin
         if (q32.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut32 unexpected done: got done=1, expected no pending result");
         end else begin
            e = q32.pop_front();
            checkOutput("dut32 Diff", diff32, e.diff);
            checkOutput("dut32 Borrow", 32'(borrow32), 32'(e.borrow));
            checkOutput("dut32 Overflow", 32'(ovf32), 32'(e.ovf));
            checkOutput("dut32 Zero", 32'(zero32), 32'(e.zero));
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input exp_t e, input string name);
      int cyc;
      int busyCnt;
      q8.push_back(e);
      @(posedge clk); #1;
      A = a;
      B = b;
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      busyCnt = busy8 ? 1 : 0;
      cyc = 0;
      while (done8 !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (busy8) busyCnt++;
      end
      checkOutput({name, " latency"}, cyc, 4);
      checkOutput({name, " busy cycles"}, busyCnt, 4);
   endtask

   task automatic randomOp(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   cyc;
      e = model(a, b);
      q8.push_back(e);
      q32.push_back(e);
      @(posedge clk); #1;
      A = a;
      B = b;
      start8 = 1'b1;
      start32 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      start32 = 1'b0;
      cyc = 0;
      while (done8 !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("random latency", cyc, 4);
   endtask

   initial begin
      #2_000_000;
      errors++;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] corners [5];
      int          cyc;
      corners = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      rst = 1'b1;
      start8 = 1'b0;
      start32 = 1'b0;
      A = '0;
      B = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset busy", 32'(busy8), 0);
      checkOutput("reset done", 32'(done8), 0);
      checkOutput("reset Diff", diff8, 0);
      checkOutput("reset Borrow", 32'(borrow8), 0);
      checkOutput("reset Overflow", 32'(ovf8), 0);
      checkOutput("reset Zero", 32'(zero8), 0);
      rst = 1'b0;

      $display("[TB] directed vectors");
      applyStimulus(32'd100, 32'd58, mk(32'd42, 1'b0, 1'b0, 1'b0), "basic");
      applyStimulus(32'h0000_0100, 32'd1, mk(32'h0000_00FF, 1'b0, 1'b0, 1'b0), "slice borrow");
      applyStimulus(32'd1, 32'd2, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0), "unsigned borrow");
      applyStimulus(32'h1234_5678, 32'h1234_5678, mk(32'd0, 1'b0, 1'b0, 1'b1), "zero");
      applyStimulus(32'h8000_0000, 32'd1, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0), "min minus one");
      applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, mk(32'h8000_0000, 1'b1, 1'b1, 1'b0), "max minus neg one");

      $display("[TB] handshake discipline");
      q8.push_back(mk(32'd999, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      A = 32'd1000;
      B = 32'd1;
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #1;
      A = 32'd77;
      B = 32'd7;
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("ignored start first done", 32'(done8), 1);
      checkOutput("ignored start first Diff", diff8, 32'd999);
      A = 32'd10;
      B = 32'd3;
      start8 = 1'b1;
      q8.push_back(mk(32'd7, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc = 1;
      while (done8 !== 1'b1 && cyc < 20) begin
         checkOutput("Diff hold during rerun", diff8, 32'd999);
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("back-to-back done interval", cyc, 5);

      $display("[TB] reset mid-operation");
      @(posedge clk); #1;
      A = 32'd100;
      B = 32'd58;
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checkOutput("async reset busy", 32'(busy8), 0);
      checkOutput("async reset done", 32'(done8), 0);
      checkOutput("async reset Diff", diff8, 0);
      checkOutput("async reset Borrow", 32'(borrow8), 0);
      checkOutput("async reset Overflow", 32'(ovf8), 0);
      checkOutput("async reset Zero", 32'(zero8), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("post-reset idle busy", 32'(busy8), 0);
      applyStimulus(32'd9, 32'd4, mk(32'd5, 1'b0, 1'b0, 1'b0), "post-reset");

      $display("[TB] corner and random pairs, SLICE 8 and 32");
      foreach (corners[i]) begin
         foreach (corners[j]) begin
            randomOp(corners[i], corners[j]);
         end
      end
      for (int n = 0; n < 10000; n++) begin
         randomOp($urandom(), $urandom());
      end

      repeat (4) @(posedge clk);
      #1;
      checkOutput("dut8 scoreboard drained", q8.size(), 0);
      checkOutput("dut32 scoreboard drained", q32.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
